// File: rtl/sar_logic_scan.sv
// sar_logic_scan
// Multi-channel successive-approximation controller. Scans the channels
// enabled in a latched mask, holds a programmable sample phase per channel,
// resolves NBITS bits by binary search on differential DAC codes and hands
// each finished code, tagged with its channel, to a one-entry valid/ready
// output register that flags overrun.
//
// Ports:
//   CLK, RSTN           clock (rising edge), asynchronous active-low reset
//   GO, CONT            start one scan when idle / restart scans back-to-back
//   CH_MASK[NCH]        enabled channels, latched at scan start
//   SAMPLE_CYC[SAMPW]   sample phase lasts SAMPLE_CYC+1 cycles
//   CMP                 comparator, 1 = input above DAC
//   SAMPLE, CH          track/hold control and analog mux select
//   RESULTP, RESULTN    P-side (bits decided 1) and N-side (bits decided 0) DAC codes
//   BUSY                controller not idle
//   DOUT, DCH, DVALID   output register (code, channel, valid)
//   DREADY              consumer accept
//   OVERRUN             one-cycle pulse when an unconsumed result is overwritten
module sar_logic_scan #(
    parameter int NBITS = 5,
    parameter int NCH   = 4,
    parameter int CHW   = 2,
    parameter int SAMPW = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             GO,
    input  logic             CONT,
    input  logic [NCH-1:0]   CH_MASK,
    input  logic [SAMPW-1:0] SAMPLE_CYC,
    input  logic             CMP,
    output logic             SAMPLE,
    output logic [CHW-1:0]   CH,
    output logic [NBITS-1:0] RESULTP,
    output logic [NBITS-1:0] RESULTN,
    output logic             BUSY,
    output logic [NBITS-1:0] DOUT,
    output logic [CHW-1:0]   DCH,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             OVERRUN
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SAMP = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [NBITS-1:0] MSB_MASK = {1'b1, {(NBITS-1){1'b0}}};

    // Lowest set bit of m at index >= start; returns {found, index}.
    // Only indices below NCH are ever considered.
    function automatic logic [CHW:0] find_from(input logic [NCH-1:0] m, input int start);
        logic [CHW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i >= start)) begin
                r = {1'b1, CHW'(i)};
            end
        end
        return r;
    endfunction

    state_t             state_r, state_n;
    logic [CHW-1:0]     ch_r, ch_n;
    logic [NBITS-1:0]   resp_r, resp_n;
    logic [NBITS-1:0]   resn_r, resn_n;
    logic [NBITS-1:0]   mask_r, mask_n;
    logic [NCH-1:0]     amask_r, amask_n;
    logic [SAMPW-1:0]   cnt_r, cnt_n;
    logic               load_s;
    logic [CHW:0]       nxt_s;
    logic [CHW:0]       first_s;
    logic               sample_r;
    logic               busy_r;
    logic [NBITS-1:0]   dout_r;
    logic [CHW-1:0]     dch_r;
    logic               dvalid_r;
    logic               overrun_r;

    // Next-state and datapath update for the scan/convert sequencer.
    always_comb begin
        state_n = state_r;
        ch_n    = ch_r;
        resp_n  = resp_r;
        resn_n  = resn_r;
        mask_n  = mask_r;
        amask_n = amask_r;
        cnt_n   = cnt_r;
        load_s  = 1'b0;
        nxt_s   = find_from(amask_r, int'(ch_r) + 32'sd1);
        first_s = find_from(CH_MASK, 32'sd0);
        case (state_r)
            S_IDLE: begin
                resp_n = '0;
                resn_n = '0;
                if (GO && (CH_MASK != '0)) begin
                    amask_n = CH_MASK;
                    ch_n    = first_s[CHW-1:0];
                    cnt_n   = SAMPLE_CYC;
                    state_n = S_SAMP;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SAMP: begin
                if (cnt_r == '0) begin
                    mask_n  = MSB_MASK;
                    resp_n  = '0;
                    resn_n  = '0;
                    state_n = S_CONV;
                end else begin
                    cnt_n = cnt_r - SAMPW'(1);
                end
            end
            S_CONV: begin
                if (CMP) begin
                    resp_n = resp_r | mask_r;
                end else begin
                    resn_n = resn_r | mask_r;
                end
                mask_n = mask_r >> 1;
                if (mask_r[0]) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_CONV;
                end
            end
            S_DONE: begin
                load_s = 1'b1;
                resp_n = '0;
                resn_n = '0;
                if (nxt_s[CHW]) begin
                    ch_n    = nxt_s[CHW-1:0];
                    cnt_n   = SAMPLE_CYC;
                    state_n = S_SAMP;
                end else if (CONT || GO) begin
                    // End of scan with a restart request: re-latch the mask.
                    amask_n = CH_MASK;
                    if (CH_MASK != '0) begin
                        ch_n    = first_s[CHW-1:0];
                        cnt_n   = SAMPLE_CYC;
                        state_n = S_SAMP;
                    end else begin
                        ch_n    = '0;
                        state_n = S_IDLE;
                    end
                end else begin
                    ch_n    = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                ch_n    = '0;
                resp_n  = '0;
                resn_n  = '0;
            end
        endcase
    end

    // Sequencer state, datapath registers and registered SAMPLE/BUSY decodes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r  <= S_IDLE;
            ch_r     <= '0;
            resp_r   <= '0;
            resn_r   <= '0;
            mask_r   <= '0;
            amask_r  <= '0;
            cnt_r    <= '0;
            sample_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            ch_r     <= ch_n;
            resp_r   <= resp_n;
            resn_r   <= resn_n;
            mask_r   <= mask_n;
            amask_r  <= amask_n;
            cnt_r    <= cnt_n;
            sample_r <= (state_n == S_SAMP);
            busy_r   <= (state_n != S_IDLE);
        end
    end

    // One-entry output register; a load wins over a same-edge handshake.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dout_r    <= '0;
            dch_r     <= '0;
            dvalid_r  <= 1'b0;
            overrun_r <= 1'b0;
        end else if (load_s) begin
            dout_r    <= resp_r;
            dch_r     <= ch_r;
            dvalid_r  <= 1'b1;
            // Overwriting is an overrun only if the old entry is not taken now.
            overrun_r <= dvalid_r & ~DREADY;
        end else begin
            overrun_r <= 1'b0;
            if (dvalid_r && DREADY) begin
                dvalid_r <= 1'b0;
            end else begin
                dvalid_r <= dvalid_r;
            end
        end
    end

    assign SAMPLE  = sample_r;
    assign BUSY    = busy_r;
    assign CH      = ch_r;
    assign RESULTP = resp_r;
    assign RESULTN = resn_r;
    assign DOUT    = dout_r;
    assign DCH     = dch_r;
    assign DVALID  = dvalid_r;
    assign OVERRUN = overrun_r;

endmodule
